// File: rtl/axis_udp_port_filter.sv
// rtl/axis_udp_port_filter.sv - AXI-Stream frame filter on UDP/IPv4 destination port
// Define AXIS_UDP_FILTER_STATS_EN to build the pass/drop frame counters.
module axis_udp_port_filter #(
   parameter int AXIS_DATA_WIDTH = 64
) (
   input  logic                         axis_s_clk,
   input  logic                         axis_s_rst_n,
   input  logic                         s_axis_tvalid,
   input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   output logic                         m_axis_tvalid,
   output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready,
   input  logic                         en_i,
   input  logic [15:0]                  cfg_dst_port_i,
   output logic [31:0]                  pass_cnt_o,
   output logic [31:0]                  drop_cnt_o
);
   localparam int BPB       = AXIS_DATA_WIDTH / 8;
   localparam int HDR_BEATS = (38 + BPB - 1) / BPB;
   localparam int CW        = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(HDR_BEATS - 1);

   typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          inc_pass, inc_drop;

   logic [AXIS_DATA_WIDTH-1:0] hbuf_data [HDR_BEATS];
   logic [BPB-1:0]             hbuf_strb [HDR_BEATS];
   logic [HDR_BEATS-1:0]       hbuf_last;

   logic        en_q;
   logic [15:0] port_q;
   logic        first, en_eff, match, in_hs;
   logic [15:0] port_eff;
   logic [8*38-1:0] hdr;

   // Config is taken live on a frame's first beat so a one-beat header still sees it.
   assign first    = (cnt == '0);
   assign en_eff   = first ? en_i : en_q;
   assign port_eff = first ? cfg_dst_port_i : port_q;
   assign in_hs    = s_axis_tvalid & s_axis_tready;

   for (genvar k = 0; k < 38; k++) begin : g_hdr
      if (k / BPB == HDR_BEATS - 1) begin : g_live
         assign hdr[8*k +: 8] = s_axis_tdata[8*(k%BPB) +: 8];
      end else begin : g_stored
         assign hdr[8*k +: 8] = hbuf_data[k/BPB][8*(k%BPB) +: 8];
      end
   end

   assign match = !en_eff ||
                  (hdr[8*12 +: 8] == 8'h08 && hdr[8*13 +: 8] == 8'h00 &&
                   hdr[8*14 +: 8] == 8'h45 && hdr[8*23 +: 8] == 8'h11 &&
                   {hdr[8*36 +: 8], hdr[8*37 +: 8]} == port_eff);

   always_ff @(posedge axis_s_clk or negedge axis_s_rst_n) begin
      if (!axis_s_rst_n) begin
         state <= HDR;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge axis_s_clk) begin
      if (state == HDR && in_hs) begin
         hbuf_data[cnt] <= s_axis_tdata;
         hbuf_strb[cnt] <= s_axis_tstrb;
         hbuf_last[cnt] <= s_axis_tlast;
         if (first) begin
            en_q   <= en_i;
            port_q <= cfg_dst_port_i;
         end
      end
   end

   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      inc_pass      = 1'b0;
      inc_drop      = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tstrb  = s_axis_tstrb;
      m_axis_tlast  = s_axis_tlast;
      case (state)
         HDR: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               if (cnt == LAST_IDX) begin
                  cnt_n = '0;
                  if (match)              state_n  = REPLAY;
                  else if (!s_axis_tlast) state_n  = DROP;
                  else                    inc_drop = 1'b1;
               end else if (s_axis_tlast) begin
                  cnt_n    = '0;
                  inc_drop = 1'b1;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         REPLAY: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = hbuf_data[cnt];
            m_axis_tstrb  = hbuf_strb[cnt];
            m_axis_tlast  = hbuf_last[cnt];
            if (m_axis_tready) begin
               if (cnt == LAST_IDX) begin
                  cnt_n = '0;
                  if (hbuf_last[cnt]) begin
                     state_n  = HDR;
                     inc_pass = 1'b1;
                  end else begin
                     state_n = PASS;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         PASS: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
               state_n  = HDR;
               inc_pass = 1'b1;
            end
         end
         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               state_n  = HDR;
               inc_drop = 1'b1;
            end
         end
         default: state_n = HDR;
      endcase
      if (!axis_s_rst_n) begin
         s_axis_tready = 1'b0;
         m_axis_tvalid = 1'b0;
      end
   end

`ifdef AXIS_UDP_FILTER_STATS_EN
   always_ff @(posedge axis_s_clk or negedge axis_s_rst_n) begin
      if (!axis_s_rst_n) begin
         pass_cnt_o <= '0;
         drop_cnt_o <= '0;
      end else begin
         if (inc_pass) pass_cnt_o <= pass_cnt_o + 32'd1;
         if (inc_drop) drop_cnt_o <= drop_cnt_o + 32'd1;
      end
   end
`else
   logic unused_inc;
   assign unused_inc = inc_pass | inc_drop;
   assign pass_cnt_o = '0;
   assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/axis_udp_port_filter.md
AXIS_UDP_PORT_FILTER -- requirements
Module: axis_udp_port_filter

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, beat width in bits; legal values are 32, 64, 128, 256 and 512.
REQ-002 SHALL derive BPB = AXIS_DATA_WIDTH/8 (bytes per beat) and HDR_BEATS = ceil(38/BPB), giving 10/5/3/2/1 for the legal widths.
REQ-003 SHALL have ports:
- axis_s_clk  in  1  single clock for all logic.
- axis_s_rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid/tdata/tstrb/tlast  in  1/W/W/8/1  AXIS slave.
- s_axis_tready  out  1  AXIS slave.
- m_axis_tvalid/tdata/tstrb/tlast  out  1/W/W/8/1  AXIS master.
- m_axis_tready  in  1  AXIS master.
- en_i  in  1  1 = filter active; 0 = every frame of at least HDR_BEATS beats passes.
- cfg_dst_port_i  in  16  UDP destination port to accept.
- pass_cnt_o  out  32  count of frames forwarded.
- drop_cnt_o  out  32  count of frames discarded.
Bytes are little-endian in lanes: byte k of the frame is at beat k/BPB, lane k%BPB, bits [8*(k%BPB)+7 : 8*(k%BPB)].

Function
REQ-004 SHALL implement the states HDR, REPLAY, PASS and DROP; reset state is HDR.
REQ-005 HDR: s_axis_tready=1 and m_axis_tvalid=0; each accepted beat (tdata, tstrb, tlast) is stored at buffer index = beat count.
REQ-006 SHALL sample en_i and cfg_dst_port_i on the first accepted beat of each frame; later changes in the same frame have no effect.
REQ-007 Match SHALL mean all of the following:
- bytes 12..13 = 0x08,0x00;
- byte 14 = 0x45;
- byte 23 = 0x11;
- bytes 36..37 = the sampled port, big-endian (byte 36 = MSB).
When the sampled en_i = 0, match SHALL be forced true.
REQ-008 Match SHALL be evaluated combinationally on the beat at index HDR_BEATS-1, using stored beats plus the live beat.
REQ-009 Transitions out of HDR:
- tlast accepted before index HDR_BEATS-1 (runt frame): stay in HDR, increment drop_cnt, clear the beat count.
- At index HDR_BEATS-1 with match: go to REPLAY.
- At index HDR_BEATS-1 without match, tlast=0: go to DROP.
- At index HDR_BEATS-1 without match, tlast=1: stay in HDR, increment drop_cnt.
REQ-010 REPLAY: s_axis_tready=0 and m_axis_tvalid=1; buffer entries 0..HDR_BEATS-1 are presented in order, each with its stored tstrb and tlast.
REQ-011 m_axis_tdata/tstrb/tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-012 Exit from REPLAY occurs on the handshake of the last buffer entry:
- If that entry had tlast=1: go to HDR and increment pass_cnt.
- Otherwise: go to PASS.
REQ-013 PASS SHALL be a zero-latency combinational bypass: m_axis_* = s_axis_*, s_axis_tready = m_axis_tready.
REQ-014 PASS exits on the tlast handshake: go to HDR and increment pass_cnt.
REQ-015 DROP: s_axis_tready=1 and m_axis_tvalid=0; beats are discarded; the tlast handshake goes to HDR and increments drop_cnt.
REQ-016 Counters SHALL wrap from 0xFFFFFFFF to 0; at most one counter increments per cycle.
REQ-017 The tstrb value SHALL be carried unmodified and SHALL NOT affect the match.

Reset
REQ-018 Asserting axis_s_rst_n low SHALL immediately force:
- state to HDR and beat count to 0;
- m_axis_tvalid=0 and s_axis_tready=0 while asserted;
- pass_cnt_o=0 and drop_cnt_o=0.
REQ-019 Reset mid-frame SHALL abandon that frame with no counter update; the first beat after release is treated as a new frame's byte 0.
REQ-020 Buffer contents need no reset; m_axis_tdata/tstrb/tlast are don't-care while m_axis_tvalid=0.

Configuration
REQ-021 Macro AXIS_UDP_FILTER_STATS_EN defined: the pass and drop counters are implemented per REQ-016.
REQ-022 Macro AXIS_UDP_FILTER_STATS_EN undefined: no counter flops exist, pass_cnt_o and drop_cnt_o are constant 0, and filtering is unchanged.

Verification
REQ-023 Directed scenarios, W=64, cfg_dst_port_i=0x1234, en_i=1:
- UDP/IPv4 frame, 9 beats, dst port 0x1234 -> 9 identical beats out, tlast on beat 9, pass_cnt=1.
- Same frame with dst port 0x1235 -> no m_axis_tvalid, s_axis_tready stays 1, drop_cnt=1.
- EtherType 0x86DD frame with en_i=0 -> forwarded intact, pass_cnt=1.
- 3-beat runt frame -> dropped, drop_cnt=1; the next valid frame still passes.
- Matching frame with m_axis_tready toggled 1,0 every cycle -> output beats stable while stalled, no beats lost or duplicated.
- axis_s_rst_n pulsed low during beat 7 of PASS -> counters 0, m_axis_tvalid=0; the following matching frame passes with pass_cnt=1.
